// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// constant-foldable ceil(log2) helper used to size counters and indices.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,   // waiting for the clock source to lock
      S_HOLD = 2'd1,   // lock seen, holding every output asserted
      S_REL  = 2'd2,   // releasing outputs one stage at a time
      S_RUN  = 2'd3    // every output released
   } state_t;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Multi-flop single-bit synchronizer that brings an asynchronous level into
// the i_clk domain. Cleared to 0 by the asynchronous reset so a lock
// indication is never trusted until it has crossed every stage.
module rst_sync #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i_d};
      end
   end

   assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / soft reset generator. Waits for clock lock, holds all resets for
// HOLD cycles, then releases o_rst[0..N_OUT-1] one after another every
// STAGGER cycles. Lock loss or a soft-reset request re-asserts every output
// on a single edge. All outputs come straight from flops.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int N_OUT   = 4,
   parameter int HOLD    = 16,
   parameter int STAGGER = 4,
   parameter int SYNC    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_locked,
   input  logic             i_req,
   output logic [N_OUT-1:0] o_rst,
   output logic             o_ready
);

   localparam int CNT_MAX = (HOLD > STAGGER) ? HOLD : STAGGER;
   localparam int CNT_W   = clog2(CNT_MAX + 1);
   localparam int IDX_W   = (N_OUT > 1) ? clog2(N_OUT) : 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
   localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(STAGGER - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);
   localparam logic [N_OUT-1:0] ALL_ON    = {N_OUT{1'b1}};

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic [N_OUT-1:0]  o_rst_q;
   logic              ready_q;
   logic              locked_s;
   logic [N_OUT-1:0]  rel_mask;

   rst_sync #(
      .STAGES (SYNC)
   ) u_lock_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_locked),
      .o_q   (locked_s)
   );

   // One-hot mask selecting the stage currently being released.
   for (genvar gi = 0; gi < N_OUT; gi++) begin : g_rel_mask
      assign rel_mask[gi] = (idx_q == IDX_W'(gi));
   end

   // Sequencer FSM: lock loss beats a soft request, which beats normal flow.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_WAIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         o_rst_q <= ALL_ON;
         ready_q <= 1'b0;
      end else if ((state_q != S_WAIT) && !locked_s) begin
         state_q <= S_WAIT;
         o_rst_q <= ALL_ON;
         ready_q <= 1'b0;
      end else if ((state_q != S_WAIT) && i_req) begin
         state_q <= S_HOLD;
         cnt_q   <= HOLD_LOAD;
         o_rst_q <= ALL_ON;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            S_WAIT: begin
               o_rst_q <= ALL_ON;
               ready_q <= 1'b0;
               if (locked_s) begin
                  cnt_q   <= HOLD_LOAD;
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (cnt_q == '0) begin
                  o_rst_q[0] <= 1'b0;
                  if (N_OUT == 1) begin
                     ready_q <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     idx_q   <= IDX_W'(1);
                     cnt_q   <= STAG_LOAD;
                     state_q <= S_REL;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_REL: begin
               if (cnt_q == '0) begin
                  o_rst_q <= o_rst_q & ~rel_mask;
                  if (idx_q == IDX_LAST) begin
                     ready_q <= 1'b1;
                     state_q <= S_RUN;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                     cnt_q <= STAG_LOAD;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_RUN: begin
               o_rst_q <= '0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_WAIT;
               o_rst_q <= ALL_ON;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign o_rst   = o_rst_q;
   assign o_ready = ready_q;

endmodule
